// File: rtl/microsequencer_stack.sv
// rtl/microsequencer_stack.sv - microprogram sequencer with subroutine stack, loop counter and map dispatch
// Optional SEQ_TRAP_EN: stack overflow/underflow vectors to TRAP_ADDR and pulses trap for one cycle.
module microsequencer_stack #(
  parameter int AW    = 12,
  parameter int DEPTH = 4,
  parameter int NCOND = 8,
  parameter int CW    = 8
`ifdef SEQ_TRAP_EN
  ,
  parameter logic [AW-1:0] TRAP_ADDR = AW'(12'hFFF)
`endif
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [2:0]                   op,
  input  logic [$clog2(NCOND)-1:0]     cond_sel,
  input  logic                         cond_inv,
  input  logic [NCOND-1:0]             cond,
  input  logic                         relative,
  input  logic [AW-1:0]                d_in,
  input  logic [AW-1:0]                map_in,
  input  logic [CW-1:0]                cnt_in,
  input  logic                         stall,
  output logic [AW-1:0]                address,
  output logic [CW-1:0]                count,
  output logic [$clog2(DEPTH+1)-1:0]   stack_depth,
  output logic                         stack_err
`ifdef SEQ_TRAP_EN
  ,
  output logic                         trap
`endif
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_NEXT  = 3'd0;
  localparam logic [2:0] OP_JUMP  = 3'd1;
  localparam logic [2:0] OP_CALL  = 3'd2;
  localparam logic [2:0] OP_RET   = 3'd3;
  localparam logic [2:0] OP_MAP   = 3'd4;
  localparam logic [2:0] OP_LOOP  = 3'd5;
  localparam logic [2:0] OP_LDCNT = 3'd6;

  logic [AW-1:0] r_stack [DEPTH];
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_depth;
  logic          r_err;

  logic          w_taken;
  logic [AW-1:0] w_target;
  logic [AW-1:0] w_inc;
  logic          w_full;
  logic          w_empty;
  logic [IW-1:0] w_push_idx;
  logic [IW-1:0] w_pop_idx;

  // Select 0 is the hard "always" condition, so cond[0] never reaches the mux output.
  assign w_taken    = ((cond_sel == '0) ? 1'b1 : cond[cond_sel]) ^ cond_inv;
  assign w_target   = relative ? (r_addr + d_in) : d_in;
  assign w_inc      = r_addr + AW'(1);
  assign w_full     = (r_depth == DW'(DEPTH));
  assign w_empty    = (r_depth == '0);
  assign w_push_idx = IW'(r_depth);
  assign w_pop_idx  = IW'(r_depth - DW'(1));

`ifdef SEQ_TRAP_EN
  logic r_trap;
  assign trap = r_trap;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_depth <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
`ifdef SEQ_TRAP_EN
      r_trap  <= 1'b0;
`endif
    end else if (!stall) begin
`ifdef SEQ_TRAP_EN
      r_trap <= 1'b0;
`endif
      case (op)
        OP_NEXT: r_addr <= w_inc;
        OP_JUMP: r_addr <= w_taken ? w_target : w_inc;
        OP_CALL: begin
          if (!w_taken) begin
            r_addr <= w_inc;
          end else if (w_full) begin
            r_err <= 1'b1;
`ifdef SEQ_TRAP_EN
            r_addr <= TRAP_ADDR;
            r_trap <= 1'b1;
`else
            r_addr <= w_target;
`endif
          end else begin
            r_stack[w_push_idx] <= w_inc;
            r_depth             <= r_depth + DW'(1);
            r_addr              <= w_target;
          end
        end
        OP_RET: begin
          if (!w_taken) begin
            r_addr <= w_inc;
          end else if (w_empty) begin
            r_err <= 1'b1;
`ifdef SEQ_TRAP_EN
            r_addr <= TRAP_ADDR;
            r_trap <= 1'b1;
`else
            r_addr <= w_inc;
`endif
          end else begin
            r_addr  <= r_stack[w_pop_idx];
            r_depth <= r_depth - DW'(1);
          end
        end
        OP_MAP: r_addr <= map_in;
        OP_LOOP: begin
          if (r_cnt != '0) begin
            r_cnt  <= r_cnt - CW'(1);
            r_addr <= w_target;
          end else begin
            r_addr <= w_inc;
          end
        end
        OP_LDCNT: begin
          r_cnt  <= cnt_in;
          r_addr <= w_inc;
        end
        default: ; // HOLD
      endcase
    end
  end

  assign address     = r_addr;
  assign count       = r_cnt;
  assign stack_depth = r_depth;
  assign stack_err   = r_err;

endmodule

// File: tb/tb_microsequencer_stack.sv
// tb/tb_microsequencer_stack.sv - directed bench with queue-based reference model for microsequencer_stack
module tb_microsequencer_stack;

  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, CALL = 3'd2, RET = 3'd3,
                         MAP = 3'd4, LOOP = 3'd5, LDCNT = 3'd6, HOLD = 3'd7;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  op = NEXT;
  logic [2:0]  cond_sel = '0;
  logic        cond_inv = 1'b0;
  logic [7:0]  cond = '0;
  logic        relative = 1'b0;
  logic [11:0] d_in = '0;
  logic [11:0] map_in = '0;
  logic [7:0]  cnt_in = '0;
  logic        stall = 1'b0;
  logic [11:0] address;
  logic [7:0]  count;
  logic [2:0]  stack_depth;
  logic        stack_err;
`ifdef SEQ_TRAP_EN
  logic        trap;
`endif

  microsequencer_stack dut (
    .clock(clock), .reset(reset), .op(op), .cond_sel(cond_sel), .cond_inv(cond_inv),
    .cond(cond), .relative(relative), .d_in(d_in), .map_in(map_in), .cnt_in(cnt_in),
    .stall(stall), .address(address), .count(count), .stack_depth(stack_depth),
    .stack_err(stack_err)
`ifdef SEQ_TRAP_EN
    , .trap(trap)
`endif
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model state
  logic [11:0] m_addr;
  logic [7:0]  m_cnt;
  logic [11:0] m_stack[$];
  logic        m_err;
  logic        m_trap;
  logic        m_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [11:0] inc, tgt;
    logic tk;
    if (reset) begin
      m_addr = '0; m_cnt = '0; m_stack.delete(); m_err = 1'b0; m_trap = 1'b0;
      return;
    end
    if (stall) return;
    inc = m_addr + 12'd1;
    tgt = relative ? m_addr + d_in : d_in;
    tk  = ((cond_sel == 3'd0) ? 1'b1 : cond[cond_sel]) ^ cond_inv;
    m_trap = 1'b0;
    case (op)
      NEXT: m_addr = inc;
      JUMP: m_addr = tk ? tgt : inc;
      CALL: begin
        if (!tk) m_addr = inc;
        else if (m_stack.size() == DEPTH) begin
          m_err = 1'b1;
`ifdef SEQ_TRAP_EN
          m_addr = 12'hFFF; m_trap = 1'b1;
`else
          m_addr = tgt;
`endif
        end else begin
          m_stack.push_back(inc);
          m_addr = tgt;
        end
      end
      RET: begin
        if (!tk) m_addr = inc;
        else if (m_stack.size() == 0) begin
          m_err = 1'b1;
`ifdef SEQ_TRAP_EN
          m_addr = 12'hFFF; m_trap = 1'b1;
`else
          m_addr = inc;
`endif
        end else m_addr = m_stack.pop_back();
      end
      MAP: m_addr = map_in;
      LOOP: begin
        if (m_cnt != 0) begin m_cnt = m_cnt - 8'd1; m_addr = tgt; end
        else m_addr = inc;
      end
      LDCNT: begin m_cnt = cnt_in; m_addr = inc; end
      default: ;
    endcase
  endtask

  always @(negedge clock) begin
    if (m_valid) begin
      chk("address", 32'(address), 32'(m_addr));
      chk("count", 32'(count), 32'(m_cnt));
      chk("stack_depth", 32'(stack_depth), 32'(m_stack.size()));
      chk("stack_err", 32'(stack_err), 32'(m_err));
`ifdef SEQ_TRAP_EN
      chk("trap", 32'(trap), 32'(m_trap));
`endif
    end
  end

  task automatic do_reset(input logic st = 1'b0);
    reset = 1'b1; op = NEXT; stall = st;
    @(posedge clock);
    model_step();
    #1;
    reset = 1'b0; stall = 1'b0; m_valid = 1'b1;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [11:0] d = 12'h0,
                       input logic [2:0] sel = 3'd0, input logic inv = 1'b0,
                       input logic [7:0] c = 8'h00, input logic rel = 1'b0,
                       input logic st = 1'b0);
    op = o; cond_sel = sel; cond_inv = inv; cond = c; relative = rel; stall = st;
    map_in = (o == MAP) ? d : 12'h5A5;
    d_in   = (o == MAP) ? 12'h333 : d;
    cnt_in = (o == LDCNT) ? d[7:0] : 8'hAA;
    @(posedge clock);
    model_step();
    #1;
  endtask

`ifdef SEQ_TRAP_EN
  localparam logic [11:0] OVF_ADDR = 12'hFFF, UNF_ADDR = 12'hFFF;
`else
  localparam logic [11:0] OVF_ADDR = 12'h500, UNF_ADDR = 12'h052;
`endif

  initial begin
    do_reset();
    chk("rst_addr", 32'(address), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    do_op(NEXT); do_op(NEXT); do_op(NEXT);
    chk("next3", 32'(address), 32'h3);
    do_op(LDCNT, 12'h007);
    do_reset(1'b1);
    chk("rst2_addr", 32'(address), 32'h0);
    chk("rst2_count", 32'(count), 32'h0);
    chk("rst2_depth", 32'(stack_depth), 32'h0);
    chk("rst2_err", 32'(stack_err), 32'h0);

    // conditional and relative jumps
    do_op(JUMP, 12'h010);
    do_op(JUMP, 12'h100, 3'd3, 1'b0, 8'h00);
    chk("jmp_nt", 32'(address), 32'h011);
    do_op(JUMP, 12'h010);
    do_op(JUMP, 12'h100, 3'd3, 1'b1, 8'h00);
    chk("jmp_inv", 32'(address), 32'h100);
    do_op(JUMP, 12'h010);
    do_op(JUMP, 12'hFFE, 3'd0, 1'b0, 8'h00, 1'b1);
    chk("jmp_rel", 32'(address), 32'h00E);
    do_op(JUMP, 12'h123, 3'd3, 1'b0, 8'h08);
    chk("jmp_c3", 32'(address), 32'h123);
    do_op(JUMP, 12'h456, 3'd0, 1'b0, 8'h01);
    chk("jmp_c0", 32'(address), 32'h456);

    // call / return nesting
    do_op(JUMP, 12'h020);
    do_op(CALL, 12'h200);
    chk("call1", 32'(address), 32'h200);
    chk("call1_d", 32'(stack_depth), 32'h1);
    do_op(CALL, 12'h300);
    chk("call2_d", 32'(stack_depth), 32'h2);
    do_op(CALL, 12'h700, 3'd1, 1'b0, 8'h00);
    chk("call_nt", 32'(address), 32'h301);
    do_op(RET, 12'h0, 3'd1, 1'b0, 8'h00);
    chk("ret_nt", 32'(address), 32'h302);
    do_op(RET);
    chk("ret1", 32'(address), 32'h201);
    do_op(RET);
    chk("ret2", 32'(address), 32'h021);
    chk("ret2_d", 32'(stack_depth), 32'h0);

    // hardware loop
    do_op(LDCNT, 12'h003);
    chk("ldcnt", 32'(count), 32'h3);
    for (int i = 0; i < 3; i++) begin
      do_op(LOOP, 12'h040);
      chk("loop_addr", 32'(address), 32'h040);
      chk("loop_cnt", 32'(count), 32'(2 - i));
    end
    do_op(LOOP, 12'h040);
    chk("loop_exit", 32'(address), 32'h041);

    // stall freezes everything
    do_op(CALL, 12'h777, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("stall_addr", 32'(address), 32'h041);
    chk("stall_d", 32'(stack_depth), 32'h0);
    do_op(LDCNT, 12'h009, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("stall_cnt", 32'(count), 32'h0);

    // overflow then underflow
    do_op(JUMP, 12'h050);
    do_op(CALL, 12'h100); do_op(CALL, 12'h200); do_op(CALL, 12'h300); do_op(CALL, 12'h400);
    chk("err_pre", 32'(stack_err), 32'h0);
    do_op(CALL, 12'h500);
    chk("ovf_addr", 32'(address), 32'(OVF_ADDR));
    chk("ovf_d", 32'(stack_depth), 32'h4);
    chk("ovf_err", 32'(stack_err), 32'h1);
`ifdef SEQ_TRAP_EN
    chk("ovf_trap", 32'(trap), 32'h1);
`endif
    do_op(RET);
    chk("pop4", 32'(address), 32'h301);
`ifdef SEQ_TRAP_EN
    chk("trap_clr", 32'(trap), 32'h0);
`endif
    do_op(RET); do_op(RET); do_op(RET);
    chk("pop1", 32'(address), 32'h051);
    do_op(RET);
    chk("unf_addr", 32'(address), 32'(UNF_ADDR));
    chk("unf_d", 32'(stack_depth), 32'h0);
    do_op(NEXT);
    chk("err_sticky", 32'(stack_err), 32'h1);

    // wrap, map dispatch, hold
    do_reset();
    chk("rst3_err", 32'(stack_err), 32'h0);
    do_op(JUMP, 12'hFFF);
    do_op(NEXT);
    chk("wrap", 32'(address), 32'h000);
    do_op(MAP, 12'h0A5, 3'd2, 1'b0, 8'h00);
    chk("map0", 32'(address), 32'h0A5);
    do_op(MAP, 12'h0A5, 3'd2, 1'b1, 8'hFF);
    chk("map1", 32'(address), 32'h0A5);
    do_op(HOLD, 12'h222);
    chk("hold", 32'(address), 32'h0A5);
    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/microsequencer_stack.md
Name: microsequencer_stack

Overview:
- Parametrised microprogram sequencer, the next generation of the CPU's fixed 12-bit sequencer.
- Generates the registered micro-PC that addresses the microcode ROM.
- Adds: configurable address width and subroutine stack depth, an N-way condition mux with polarity inversion, a hardware loop counter, map dispatch, and stack error detection.
- Driven by fields of the microcode pipeline register and by the instruction map ROM output.

Parameters:
- AW, 12: micro-address width.
- DEPTH, 4: subroutine stack entries (≥1).
- NCOND, 8: condition inputs (power of 2, ≥2).
- CW, 8: loop counter width.
- TRAP_ADDR, 12'hFFF: trap vector (AW bits); used only with SEQ_TRAP_EN.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- op  in  3  0 NEXT, 1 JUMP, 2 CALL, 3 RET, 4 MAP, 5 LOOP, 6 LDCNT, 7 HOLD.
- cond_sel  in  log2(NCOND)  condition select; 0 = always true.
- cond_inv  in  1  invert selected condition.
- cond  in  NCOND  condition inputs; bit 0 is ignored.
- relative  in  1  target = address + d_in instead of d_in.
- d_in  in  AW  jump/call/loop target or relative offset.
- map_in  in  AW  dispatch address from the map ROM.
- cnt_in  in  CW  loop counter load value.
- stall  in  1  freeze all state.
- address  out  AW  registered micro-PC.
- count  out  CW  loop counter.
- stack_depth  out  clog2(DEPTH+1)  occupied stack entries.
- stack_err  out  1  sticky stack overflow/underflow flag.

Behaviour:
- Reset (synchronous, has priority over stall):
  - address = 0, count = 0, stack_depth = 0, stack_err = 0.
  - Stack entries cleared to 0.
  - trap = 0 when present.
- Latency: op and its operands are sampled on a clock edge; address reflects the result after that edge. One-cycle latency; no combinational path from inputs to address.
- taken = ((cond_sel==0) ? 1 : cond[cond_sel]) ^ cond_inv.
- target = relative ? address + d_in : d_in, truncated to AW bits (wraps modulo 2^AW).
- inc = address + 1, wraps from 2^AW-1 to 0.
- Operations:
  - NEXT: address <= inc.
  - JUMP: address <= taken ? target : inc.
  - CALL:
    - If taken: push inc, address <= target.
    - Else address <= inc and the stack is unchanged.
  - RET:
    - If taken: address <= top of stack, pop.
    - Else address <= inc.
  - MAP: address <= map_in; the condition is ignored.
  - LOOP (condition ignored):
    - count != 0: count <= count-1, address <= target.
    - count == 0: address <= inc, count stays 0.
  - LDCNT: count <= cnt_in, address <= inc.
  - HOLD: address unchanged; nothing else changes.
- stall=1: address, count, stack, stack_err and trap all hold, regardless of op.
- Stack: LIFO, stack_depth ranges 0..DEPTH. A taken CALL at depth k writes entry k and sets depth k+1. A taken RET reads entry depth-1.
- Overflow (taken CALL with depth==DEPTH), no trap feature:
  - Push is dropped and depth is unchanged.
  - The jump to target still occurs.
  - stack_err <= 1.
- Underflow (taken RET with depth==0), no trap feature:
  - address <= inc, depth stays 0.
  - stack_err <= 1.
- stack_err clears only on reset.
- No other state is affected by the condition inputs.

Optional Feature:
- Macro: SEQ_TRAP_EN.
- Defined:
  - Adds output port trap (out, 1).
  - On overflow or underflow: address <= TRAP_ADDR, stack unchanged, stack_err <= 1, trap = 1 for exactly the following cycle.
  - trap is registered; it deasserts next edge unless a new error occurs.
- Undefined: no trap port; overflow/underflow behave as described in Behaviour.

Test Plan:
- Reset then NEXT ×3 → address 0,1,2,3. Then reset=1 for one edge → address 0, count 0, stack_depth 0, stack_err 0.
- Conditional jump:
  - address=0x010, JUMP cond_sel=3, cond[3]=0, cond_inv=0, d_in=0x100 → 0x011.
  - Same with cond_inv=1 → 0x100.
  - relative=1, d_in=0xFFE at 0x010 → 0x00E.
- Call/return:
  - CALL at 0x020 to 0x200 → address 0x200, depth 1.
  - Nested CALL at 0x200 to 0x300 → depth 2.
  - RET → 0x201. RET → 0x021, depth 0.
- Loop counter: LDCNT cnt_in=3, then LOOP d_in=0x040 repeated → branches to 0x040 three times (count 2,1,0), fourth LOOP falls through to inc.
- Stack errors, DEPTH=4:
  - Five taken CALLs → depth stays 4, stack_err=1, 5th still jumps.
  - Without SEQ_TRAP_EN, RET on empty → address inc.
  - With SEQ_TRAP_EN, either error → address 0xFFF and trap high for one cycle.
- Stall and wrap:
  - stall=1 during CALL → address/depth unchanged.
  - NEXT at 0xFFF → 0x000.
  - MAP map_in=0x0A5 → 0x0A5 regardless of cond.
